// File: rtl/lc3_decode_pkg.sv
// Shared definitions for the LC3 decode stage: opcodes, control-word layout
// and writeback encodings.
package lc3_decode_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // E_control = {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
    localparam int E_ALU_LSB = 4;
    localparam int E_PC1_LSB = 2;
    localparam int E_PC2_BIT = 1;
    localparam int E_OP2_BIT = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PC1_NONE    = 2'b00;
    localparam logic [1:0] PC1_OFFSET9 = 2'b01;
    localparam logic [1:0] PC1_OFFSET6 = 2'b10;
    localparam logic [1:0] PC1_ZERO    = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic [5:0] e;
        logic       m;
        logic [1:0] w;
    } ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder producing the execute, memory and writeback
// control words for one LC3 instruction.
module lc3_decode_ctrl
    import lc3_decode_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic       ir5_i,
    output logic [5:0] e_control_o,
    output logic       m_control_o,
    output logic [1:0] w_control_o
);

    ctrl_t      ctrl;
    logic [1:0] aluSel;
    logic [1:0] pc1Sel;
    logic       pc2Sel;
    logic       op2Sel;

    always_comb begin
        aluSel = ALU_ADD;
        pc1Sel = PC1_NONE;
        pc2Sel = 1'b0;
        op2Sel = 1'b0;
        ctrl   = '0;
        ctrl.w = WB_ALU;

        // Unsupported opcodes fall through to the all-zero defaults.
        case (opcode_i)
            OP_ADD: begin
                aluSel = ALU_ADD;
                op2Sel = ~ir5_i;
            end
            OP_AND: begin
                aluSel = ALU_AND;
                op2Sel = ~ir5_i;
            end
            OP_NOT: aluSel = ALU_NOT;
            OP_BR, OP_ST: begin
                pc1Sel = PC1_OFFSET9;
                pc2Sel = 1'b1;
            end
            OP_LD: begin
                pc1Sel = PC1_OFFSET9;
                pc2Sel = 1'b1;
                ctrl.w = WB_MEM;
            end
            OP_LDI: begin
                pc1Sel = PC1_OFFSET9;
                pc2Sel = 1'b1;
                ctrl.m = 1'b1;
                ctrl.w = WB_MEM;
            end
            OP_STI: begin
                pc1Sel = PC1_OFFSET9;
                pc2Sel = 1'b1;
                ctrl.m = 1'b1;
            end
            OP_LEA: begin
                pc1Sel = PC1_OFFSET9;
                pc2Sel = 1'b1;
                ctrl.w = WB_PC;
            end
            OP_LDR: begin
                pc1Sel = PC1_OFFSET6;
                ctrl.w = WB_MEM;
            end
            OP_STR: pc1Sel = PC1_OFFSET6;
            OP_JMP: pc1Sel = PC1_ZERO;
            default: ;
        endcase

        ctrl.e[E_ALU_LSB +: 2] = aluSel;
        ctrl.e[E_PC1_LSB +: 2] = pc1Sel;
        ctrl.e[E_PC2_BIT]      = pc2Sel;
        ctrl.e[E_OP2_BIT]      = op2Sel;
    end

    assign e_control_o = ctrl.e;
    assign m_control_o = ctrl.m;
    assign w_control_o = ctrl.w;

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 decode stage: enabled pipeline register holding the fetched
// instruction, its next-PC and the control words decoded from it.
module lc3_decode_stage
    import lc3_decode_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_decode,
    input  logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] npc_in,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] npc_out,
    output logic [5:0]       E_control,
    output logic             M_control,
    output logic [1:0]       W_control
);

    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] npc_q;
    logic [5:0]       e_q;
    logic             m_q;
    logic [1:0]       w_q;

    logic [5:0]       e_d;
    logic             m_d;
    logic [1:0]       w_d;

    lc3_decode_ctrl u_ctrl (
        .opcode_i    (dout[15:12]),
        .ir5_i       (dout[5]),
        .e_control_o (e_d),
        .m_control_o (m_d),
        .w_control_o (w_d)
    );

    // Pure enabled register; stalls are owned by the controller.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            m_q   <= 1'b0;
            w_q   <= '0;
        end else if (enable_decode) begin
            ir_q  <= dout;
            npc_q <= npc_in;
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
        end
    end

    assign IR        = ir_q;
    assign npc_out   = npc_q;
    assign E_control = e_q;
    assign M_control = m_q;
    assign W_control = w_q;

endmodule
